sram_bitline_ctrl: RTL and testbench
====================================

// Module: sram_bitline_ctrl
// PURPOSE
// Array-side driver for the differential 6T sram_cell array: sequences precharge, wordline and
// bitline-pair drive per access, and captures cell data_out for reads. Sits between the
// request interface and a ROWS x DATA_W cell array (one wordline per row, one bitline pair per column).
// Issues one request at a time; completion signalled by a single-cycle done pulse.
// PARAMETERS
// ADDR_W     4   row address width; ROWS = 2**ADDR_W wordlines
// DATA_W     8   columns (bits per word); one bitline pair per column
// PRECH_CYC  2   cycles of bitline precharge before a read wordline (>=1)
// WL_CYC     2   cycles wordline held high per access (>=1)
// PORTS
// clk        in   1           rising-edge clock
// reset      in   1           asynchronous, active-high reset
// req        in   1           access request; accepted when req && ready
// we         in   1           1 = write, 0 = read; sampled at accept
// addr       in   ADDR_W      row address; sampled at accept
// wdata      in   DATA_W      write word; sampled at accept
// ready      out  1           idle, request may be accepted this cycle
// done       out  1           one-cycle completion pulse (read or write)
// rdata      out  DATA_W      read word, valid from done cycle, held until next read done
// wl         out  2**ADDR_W   wordlines (cell select), one-hot or all-zero
// bl         out  2*DATA_W    bitline pairs: bl[2k]=cell data_in[0], bl[2k+1]=cell data_in[1]
// bl_oe      out  1           bitline drivers enabled (write only)
// precharge  out  1           bitline precharge enable (read only)
// sense_in   in   DATA_W      per-column cell data_out of the selected row
// BEHAVIOUR
// - States: IDLE, PRECH, ACCESS, RECOVER, DONE; all outputs registered except ready (=state==IDLE && !reset).
// - Reset (async): state IDLE; wl=0, bl=0, bl_oe=0, precharge=0, done=0, rdata=0; ready=0 while reset high.
// - IDLE: req&&ready latches we/addr/wdata. Read -> PRECH; write -> ACCESS. req otherwise ignored.
// - PRECH (read): precharge=1, wl=0, bl_oe=0 for PRECH_CYC cycles -> ACCESS.
// - ACCESS: wl[addr]=1 for WL_CYC cycles. Write: bl_oe=1, bl[2k]=wdata[k], bl[2k+1]=~wdata[k].
//   Read: bl_oe=0, precharge=0; sense_in captured into rdata on the last ACCESS clock edge.
//   Exit: read -> DONE; write -> RECOVER.
// - RECOVER (write only): wl=0, bl_oe and bl held 1 cycle (wordline falls before drivers release) -> DONE.
// - DONE: done=1 one cycle, outputs quiet (wl=0, bl_oe=0, precharge=0, bl=0) -> IDLE.
// - Latency, accept edge = edge 0: read done high in cycle PRECH_CYC+WL_CYC+1 (defaults: cycle 5);
//   write done in cycle WL_CYC+2 (defaults: 4). ready returns the cycle after done.
// - Invariants: never precharge&&wl!=0; never precharge&&bl_oe; $onehot0(wl); bl_oe only in write ACCESS/RECOVER.
// - Cycle counter sized $clog2(max(PRECH_CYC,WL_CYC)+1); reloaded on each state entry, no wrap.
// - Reset mid-operation: all wordlines/drivers drop asynchronously, request aborted, no done pulse;
//   contents of a row being written are undefined. rdata reset to 0.
// - addr covers all ROWS; no out-of-range case. wdata/addr changes after accept have no effect.
// TESTING
// - Reset: reset=1 mid-ACCESS -> wl=0, bl_oe=0, precharge=0, done=0, rdata=0 immediately; ready=1 after release.
// - Write addr=3 wdata=8'hA5 -> wl=16'h0008 cycles 1-2, bl=16'h6699, bl_oe=1 cycles 1-3, done cycle 4.
// - Read addr=3 on 8'hA5 in row -> precharge cycles 1-2, wl=16'h0008 cycles 3-4, done cycle 5, rdata=8'hA5.
// - Back-to-back: req held high for write then read -> second accepted only in cycle after done; no overlap.
// - req while busy (addr=7) -> ignored; no wl[7] ever; invariants checked by assertions every cycle.
// - Params PRECH_CYC=1, WL_CYC=1: read done cycle 3, write done cycle 3; write all-ones/all-zeros per row, read back.

Source files
------------

// File: rtl/sram_bitline_ctrl.sv
// Array-side sequencer for a differential 6T SRAM: precharge, wordline and
// bitline-pair drive per access, with read data captured from the sense lines.
module sram_bitline_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int PRECH_CYC = 2,
  parameter int WL_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic [2**ADDR_W-1:0]  wl,
  output logic [2*DATA_W-1:0]   bl,
  output logic                  bl_oe,
  output logic                  precharge,
  input  logic [DATA_W-1:0]     sense_in
);

  localparam int ROWS = 2**ADDR_W;
  localparam int MAXC = (PRECH_CYC > WL_CYC) ? PRECH_CYC : WL_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, PRECH, ACCESS, RECOVER, DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ROWS-1:0]     wl_q;
  logic [2*DATA_W-1:0] bl_q;
  logic                bl_oe_q;
  logic                prech_q;
  logic                done_q;
  logic [2*DATA_W-1:0] bl_d;

  // Each column pair carries true on the even line, complement on the odd.
  always_comb begin
    bl_d = '0;
    for (int k = 0; k < DATA_W; k++) begin
      bl_d[2*k]   = wdata[k];
      bl_d[2*k+1] = ~wdata[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      wl_q    <= '0;
      bl_q    <= '0;
      bl_oe_q <= 1'b0;
      prech_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= addr;
            if (we) begin
              state_q <= ACCESS;
              cnt_q   <= CW'(WL_CYC - 1);
              wl_q    <= ROWS'(1) << addr;
              bl_q    <= bl_d;
              bl_oe_q <= 1'b1;
            end else begin
              state_q <= PRECH;
              cnt_q   <= CW'(PRECH_CYC - 1);
              prech_q <= 1'b1;
            end
          end
        end
        PRECH: begin
          if (cnt_q == '0) begin
            state_q <= ACCESS;
            cnt_q   <= CW'(WL_CYC - 1);
            prech_q <= 1'b0;
            wl_q    <= ROWS'(1) << addr_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            wl_q  <= '0;
            cnt_q <= '0;
            if (we_q) begin
              state_q <= RECOVER;
            end else begin
              state_q <= DONE;
              rdata_q <= sense_in;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // Drivers outlive the wordline by one cycle.
        RECOVER: begin
          state_q <= DONE;
          bl_oe_q <= 1'b0;
          bl_q    <= '0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_q == IDLE) && !reset;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign wl        = wl_q;
  assign bl        = bl_q;
  assign bl_oe     = bl_oe_q;
  assign precharge = prech_q;

endmodule

// File: tb/tb_sram_bitline_ctrl.sv
// Bench for sram_bitline_ctrl: cell-array model, scoreboard of done/rdata,
// directed waveform checks, default and minimum-timing instances.
module tb_sram_bitline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  addr  [2];
  logic [7:0]  wdata [2];
  logic        rdy   [2];
  logic        done  [2];
  logic [7:0]  rdata [2];
  logic [15:0] wl    [2];
  logic [15:0] bl    [2];
  logic        bloe  [2];
  logic        prech [2];
  logic [7:0]  sense [2];

  logic [7:0]  mem  [2][16];
  logic [7:0]  refm [2][16];

  typedef struct {
    int         u;
    bit         w;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   seen7 = 1'b0;

  always #5 clk = ~clk;

  sram_bitline_ctrl u0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(rdy[0]),
    .done(done[0]), .rdata(rdata[0]), .wl(wl[0]), .bl(bl[0]),
    .bl_oe(bloe[0]), .precharge(prech[0]), .sense_in(sense[0])
  );

  sram_bitline_ctrl #(.PRECH_CYC(1), .WL_CYC(1)) u1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(rdy[1]),
    .done(done[1]), .rdata(rdata[1]), .wl(wl[1]), .bl(bl[1]),
    .bl_oe(bloe[1]), .precharge(prech[1]), .sense_in(sense[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int u, input bit w);
    int p = (u == 0) ? 2 : 1;
    int l = (u == 0) ? 2 : 1;
    return w ? l + 2 : p + l + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cell array: bl[2k] is the true data line of column k.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (bloe[u])
        for (int r = 0; r < 16; r++)
          if (wl[u][r])
            for (int k = 0; k < 8; k++)
              mem[u][r][k] <= bl[u][2*k];
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      sense[u] = '0;
      for (int r = 0; r < 16; r++)
        if (wl[u][r]) sense[u] = mem[u][r];
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic viol;
      exp_t e;
      viol = (prech[u] && wl[u] != 0) || (prech[u] && bloe[u]) ||
             !$onehot0(wl[u]) ||
             (bloe[u] && ((bl[u] ^ (bl[u] >> 1)) & 16'h5555) != 16'h5555);
      chk($sformatf("invariant%0d", u), {31'd0, viol}, 0);
      if (done[u] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_unit", u, e.u);
          chk("done_cycle", cyc, e.cyc);
          if (!e.w) chk("rdata", {24'd0, rdata[u]}, {24'd0, e.d});
        end
      end
    end
    if (wl[0][7]) seen7 = 1'b1;
  end

  task automatic issue(input int u, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input bit hold,
                       output int waits);
    exp_t e;
    int n = 0;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    while (!rdy[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    waits = n;
    if (!rdy[u]) begin
      chk("accept_timeout", 0, 1);
      req[u] = 1'b0;
      return;
    end
    e.u = u; e.w = w; e.cyc = cyc + lat(u, w);
    e.d = w ? 8'h00 : refm[u][a];
    if (w) refm[u][a] = d;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req[u] = 1'b0;
    addr[u] = ~a; wdata[u] = ~d;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while ((sb.size() != 0 || !rdy[u]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, rdy[u]}, 1);
  endtask

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      req[u] = 0; we[u] = 0; addr[u] = 0; wdata[u] = 0;
      for (int r = 0; r < 16; r++) begin
        mem[u][r] = 8'h00;
        refm[u][r] = 8'h00;
      end
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy[0]}, 0);
    chk("rst_wl", {16'd0, wl[0]}, 0);
    chk("rst_done", {31'd0, done[0]}, 0);
    chk("rst_rdata", {24'd0, rdata[0]}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {30'd0, rdy[1], rdy[0]}, 3);

    // Write A5 to row 3: waveform by cycle
    issue(0, 1'b1, 4'd3, 8'hA5, 1'b0, n);
    for (int k = 1; k <= 4; k++) begin
      chk("w_wl", {16'd0, wl[0]}, (k <= 2) ? 32'h0008 : 32'h0);
      chk("w_bl", {16'd0, bl[0]}, (k <= 3) ? 32'h6699 : 32'h0);
      chk("w_bloe", {31'd0, bloe[0]}, (k <= 3) ? 1 : 0);
      chk("w_done", {31'd0, done[0]}, (k == 4) ? 1 : 0);
      @(negedge clk);
    end
    chk("w_ready_after", {31'd0, rdy[0]}, 1);

    // Read row 3
    issue(0, 1'b0, 4'd3, 8'h00, 1'b0, n);
    for (int k = 1; k <= 5; k++) begin
      chk("r_prech", {31'd0, prech[0]}, (k <= 2) ? 1 : 0);
      chk("r_wl", {16'd0, wl[0]}, (k == 3 || k == 4) ? 32'h0008 : 32'h0);
      chk("r_bloe", {31'd0, bloe[0]}, 0);
      chk("r_done", {31'd0, done[0]}, (k == 5) ? 1 : 0);
      chk("r_ready", {31'd0, rdy[0]}, 0);
      @(negedge clk);
    end
    chk("r_ready_after", {31'd0, rdy[0]}, 1);

    // Back-to-back with req held high
    issue(0, 1'b1, 4'd5, 8'h3C, 1'b1, n);
    issue(0, 1'b0, 4'd5, 8'h00, 1'b0, n);
    chk("b2b_wait", n, 4);
    wait_idle(0);

    // Request while busy is ignored
    seen7 = 1'b0;
    issue(0, 1'b0, 4'd3, 8'h00, 1'b0, n);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd7; wdata[0] = 8'hFF;
    repeat (4) @(negedge clk);
    req[0] = 1'b0;
    wait_idle(0);
    chk("busy_no_wl7", {31'd0, seen7}, 0);

    // Reset in the middle of a write
    issue(0, 1'b1, 4'd9, 8'h5A, 1'b0, n);
    reset = 1'b1;
    #1;
    chk("mid_rst_wl", {16'd0, wl[0]}, 0);
    chk("mid_rst_bloe", {31'd0, bloe[0]}, 0);
    chk("mid_rst_prech", {31'd0, prech[0]}, 0);
    chk("mid_rst_done", {31'd0, done[0]}, 0);
    chk("mid_rst_rdata", {24'd0, rdata[0]}, 0);
    chk("mid_rst_ready", {31'd0, rdy[0]}, 0);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", {31'd0, rdy[0]}, 1);
    issue(0, 1'b0, 4'd3, 8'h00, 1'b0, n);
    wait_idle(0);

    // Minimum timing: all-ones then all-zeros over every row
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 16; r++)
        issue(1, 1'b1, 4'(r), (p == 0) ? 8'hFF : 8'h00, 1'b0, n);
      for (int r = 0; r < 16; r++)
        issue(1, 1'b0, 4'(r), 8'h00, 1'b0, n);
    end
    wait_idle(1);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
